cond_unit: RTL and testbench
============================

# cond_unit

Execute-stage condition unit for the pipelined processor: the consumer of the ALU's `{N,Z,C,V}` flag output. Holds the architectural NZCV flags register. Evaluates each instruction's 4-bit condition field against the current flags and gates the instruction's register-write, memory-write and PC-redirect controls. Also keeps a saturating count of instructions squashed by a failed condition, for performance debug.

## Interface
- `CNT_W`, default 16: width of the squashed-instruction counter.

- `clk`  in  1: processor clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ValidE`  in  1: the execute stage holds a real instruction (0 = bubble).
- `CondE`  in  4: instruction condition field, Instr[31:28].
- `ALUFlags`  in  4: `{N,Z,C,V}` from the ALU for the current execute instruction.
- `FlagWriteE`  in  2: bit 1 updates N,Z; bit 0 updates C,V.
- `RegWriteE`, `MemWriteE`, `PCSrcE`  in  1 each: ungated decoder controls.
- `StallE`  in  1: hazard unit holds the execute stage this cycle.
- `FlushE`  in  1: hazard unit kills the execute-stage instruction this cycle.
- `CondExE`  out  1: the condition passed for a valid, unflushed instruction.
- `RegWriteGE`, `MemWriteGE`, `PCSrcGE`  out  1 each: each ungated control ANDed with `CondExE`.
- `Flags`  out  4: the current registered `{N,Z,C,V}`.
- `SquashCnt`  out  CNT_W: count of valid instructions whose condition failed.

## Operation
- **Condition decode** (`cond_ok`, computed from the registered `Flags`, never from `ALUFlags`):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C & !Z. 1001 LS: !C | Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V).
  - 1110 AL: 1. 1111 NV (reserved): 0.
- **Pass signal:** `CondExE = ValidE & ~FlushE & cond_ok`.
- **Gated outputs:** all gated outputs and `CondExE` are combinational. There is no added latency.
- **Flags update** on the rising edge, when `CondExE & ~StallE`:
  - if `FlagWriteE[1]`: `Flags[3:2] <= ALUFlags[3:2]`.
  - if `FlagWriteE[0]`: `Flags[1:0] <= ALUFlags[1:0]`.
  - Bits not selected hold their value.
- **Squash counter:** increments by 1 when `ValidE & ~FlushE & ~StallE & ~cond_ok`. It saturates at all-ones and never wraps.
- **While stalled:** the flags and counter hold. Gated outputs still reflect the current inputs, and the hazard unit is responsible for ignoring them.
- **Flush:** `FlushE` takes priority over everything. No flag update, no count, all gated outputs 0.

## Timing
- **Reset:** `reset_n` low immediately (asynchronously) forces `Flags = 4'b0000` and `SquashCnt = 0`. Both hold until the first rising edge after `reset_n` returns high.
- **After reset:** with all-zero flags, EQ fails and NE passes.
- **Reset mid-operation:** it discards any pending flag update on that edge.
- **Combinational path:** from `CondE`, `ValidE`, `FlushE` and `Flags` to `CondExE` and the gated outputs, within the same cycle.
- **Flag visibility:** flags written by the instruction in cycle t are visible to the condition check of the instruction in cycle t+1. This means back-to-back CMP then BEQ works without forwarding.
- **Self-conditioning:** an instruction that sets flags is conditioned on the old flags, never its own result.
- **Simultaneous `StallE` and `FlushE`:** treated as a flush for outputs. State holds.

## Test plan
- **Reset behaviour:** drop `reset_n` mid-cycle with `Flags=4'b1111` → `Flags=0` and `SquashCnt=0` immediately, without waiting for a clock. Then CondE=0000 with RegWriteE=1 → `RegWriteGE=0`, `SquashCnt=1` next cycle.
- **CMP then branch:** set-flags instruction with ALUFlags=0100, FlagWriteE=11, CondE=1110. Next cycle CondE=0000 (EQ) with PCSrcE=1 → `PCSrcGE=1`, `Flags=0100`.
- **Partial flag write:** Flags=1111, then ALUFlags=0000 with FlagWriteE=10 → `Flags=0011`. Then FlagWriteE=01 → `Flags=0000`.
- **Signed conditions:** with Flags N=1,V=0 → GE fails, LT passes, GT fails, LE passes. With N=1,V=1,Z=0 → GT passes. CondE=1111 → `CondExE=0`.
- **Stall and flush:** with StallE=1 and a passing flag-setting instruction → `Flags` unchanged, `RegWriteGE=1`. With FlushE=1 and a failing condition → `SquashCnt` unchanged, all gated outputs 0.
- **Counter saturation:** with CNT_W=4, issue 20 failing valid instructions → `SquashCnt=15`, with no wrap.

Source files
------------

// File: rtl/cond_unit_if.sv
// Execute-stage condition unit bundle: decoder/hazard controls in, gated controls and state out.
// The master drives the instruction side; the condition unit is the slave.
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic             ValidE;
  logic [3:0]       CondE;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagWriteE;
  logic             RegWriteE;
  logic             MemWriteE;
  logic             PCSrcE;
  logic             StallE;
  logic             FlushE;
  logic             CondExE;
  logic             RegWriteGE;
  logic             MemWriteGE;
  logic             PCSrcGE;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCnt;

  modport master (
    output ValidE, CondE, ALUFlags, FlagWriteE, RegWriteE, MemWriteE, PCSrcE, StallE, FlushE,
    input  CondExE, RegWriteGE, MemWriteGE, PCSrcGE, Flags, SquashCnt
  );

  modport slave (
    input  ValidE, CondE, ALUFlags, FlagWriteE, RegWriteE, MemWriteE, PCSrcE, StallE, FlushE,
    output CondExE, RegWriteGE, MemWriteGE, PCSrcGE, Flags, SquashCnt
  );
endinterface

// File: rtl/cond_unit.sv
// Condition unit: holds NZCV, evaluates the condition field against the registered flags,
// gates write/branch controls and counts condition-squashed instructions (saturating).
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  cond_unit_if.slave  bus
);

  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] squash_cnt_q;
  logic [CNT_W-1:0] squash_cnt_d;

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic cond_ok;
  logic live;
  logic cond_ex;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluated on the registered flags, so a flag-setting instruction sees the old values.
  always_comb begin
    cond_ok = 1'b0;
    case (bus.CondE)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ok = flag_z | (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign live    = bus.ValidE & ~bus.FlushE;
  assign cond_ex = live & cond_ok;

  assign bus.CondExE    = cond_ex;
  assign bus.RegWriteGE = bus.RegWriteE & cond_ex;
  assign bus.MemWriteGE = bus.MemWriteE & cond_ex;
  assign bus.PCSrcGE    = bus.PCSrcE & cond_ex;
  assign bus.Flags      = flags_q;
  assign bus.SquashCnt  = squash_cnt_q;

  always_comb begin
    flags_d = flags_q;
    if (cond_ex && !bus.StallE) begin
      if (bus.FlagWriteE[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagWriteE[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (live && !bus.StallE && !cond_ok && (squash_cnt_q != {CNT_W{1'b1}})) begin
      squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q      <= 4'b0000;
      squash_cnt_q <= '0;
    end else begin
      flags_q      <= flags_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a reference model pushes expected outputs per issued
// instruction into a scoreboard queue; each scenario task pops and compares inline.
module tb_cond_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cond_unit_if #(.CNT_W(16)) bus ();
  cond_unit_if #(.CNT_W(4))  bus4 ();

  cond_unit #(.CNT_W(16)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  cond_unit #(.CNT_W(4))  dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));

  typedef struct {
    logic        cx;
    logic        rg;
    logic        mg;
    logic        pg;
    logic [3:0]  fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;
  int          checks = 0;
  int          passed = 0;

  // Canonical ARM form: base test selected by cond[3:1], cond[0] inverts, 1111 never passes.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !b : b;
  endfunction

  task automatic issue(input logic v, input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] fw, input logic rw, input logic mw, input logic pc,
                       input logic st, input logic fl);
    exp_t x;
    logic pass;
    bus.ValidE = v; bus.CondE = cond; bus.ALUFlags = alu; bus.FlagWriteE = fw;
    bus.RegWriteE = rw; bus.MemWriteE = mw; bus.PCSrcE = pc; bus.StallE = st; bus.FlushE = fl;
    pass  = v && !fl && ref_cond(cond, m_flags);
    x.cx  = pass;
    x.rg  = rw && pass;
    x.mg  = mw && pass;
    x.pg  = pc && pass;
    x.fl  = m_flags;
    x.cnt = m_cnt;
    sb.push_back(x);
    #2;
  endtask

  task automatic tick();
    logic       ok, live;
    logic [3:0] nf;
    logic [15:0] nc;
    ok   = ref_cond(bus.CondE, m_flags);
    live = bus.ValidE && !bus.FlushE && !bus.StallE;
    nf = m_flags;
    nc = m_cnt;
    if (live && ok) begin
      if (bus.FlagWriteE[1]) nf[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagWriteE[0]) nf[1:0] = bus.ALUFlags[1:0];
    end
    if (live && !ok && nc != 16'hFFFF) nc = nc + 16'd1;
    @(posedge clk);
    if (reset_n) begin
      m_flags = nf;
      m_cnt   = nc;
    end
    #1;
  endtask

  task automatic idle();
    bus.ValidE = 0; bus.CondE = 4'b1110; bus.ALUFlags = 0; bus.FlagWriteE = 0;
    bus.RegWriteE = 0; bus.MemWriteE = 0; bus.PCSrcE = 0; bus.StallE = 0; bus.FlushE = 0;
  endtask

  task automatic test_reset();
    idle();
    bus4.ValidE = 0; bus4.CondE = 0; bus4.ALUFlags = 0; bus4.FlagWriteE = 0;
    bus4.RegWriteE = 0; bus4.MemWriteE = 0; bus4.PCSrcE = 0; bus4.StallE = 0; bus4.FlushE = 0;
    reset_n = 1'b0; m_flags = 0; m_cnt = 0;
    #3;
    checks++; if (bus.Flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", bus.Flags); else passed++;
    checks++; if (bus.SquashCnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bus.SquashCnt); else passed++;
    @(posedge clk); #3; reset_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    checks++; if (bus.Flags !== 4'b1111) $display("FAIL preload_flags: got %b want 1111", bus.Flags); else passed++;
    $display("reset: flags preloaded to %b", bus.Flags);
    #3; reset_n = 1'b0; #1;
    m_flags = 0; m_cnt = 0;
    checks++; if (bus.Flags !== 4'b0000) $display("FAIL async_reset_flags: got %b want 0000", bus.Flags); else passed++;
    checks++; if (bus.SquashCnt !== 16'd0) $display("FAIL async_reset_cnt: got %0d want 0", bus.SquashCnt); else passed++;
    // Hold reset across an edge carrying a passing flag write: the write must be discarded.
    @(posedge clk); #1;
    issue(1, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    checks++; if (bus.Flags !== 4'b0000) $display("FAIL reset_discard: got %b want 0000", bus.Flags); else passed++;
    #2; reset_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0); e = sb.pop_front();
    checks++; if (bus.RegWriteGE !== 1'b0) $display("FAIL eq_after_reset_rg: got %b want 0", bus.RegWriteGE); else passed++;
    tick();
    checks++; if (bus.SquashCnt !== 16'd1) $display("FAIL eq_after_reset_cnt: got %0d want 1", bus.SquashCnt); else passed++;
    issue(1, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 0); e = sb.pop_front();
    checks++; if (bus.CondExE !== 1'b1) $display("FAIL ne_after_reset: got %b want 1", bus.CondExE); else passed++;
    tick();
    $display("reset: squash count %0d", bus.SquashCnt);
  endtask

  task automatic test_cmp_branch();
    issue(1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front();
    checks++; if (bus.CondExE !== e.cx) $display("FAIL cmp_condex: got %b want %b", bus.CondExE, e.cx); else passed++;
    tick();
    issue(1, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 0); e = sb.pop_front();
    checks++; if (bus.PCSrcGE !== 1'b1) $display("FAIL beq_pcsrc: got %b want 1", bus.PCSrcGE); else passed++;
    checks++; if (bus.Flags !== 4'b0100) $display("FAIL beq_flags: got %b want 0100", bus.Flags); else passed++;
    tick();
    // NE fails on the old Z=1 even though its own ALU result would clear Z.
    issue(1, 4'b0001, 4'b0000, 2'b11, 1, 1, 0, 0, 0); e = sb.pop_front();
    checks++; if (bus.CondExE !== 1'b0) $display("FAIL self_cond_condex: got %b want 0", bus.CondExE); else passed++;
    tick();
    checks++; if (bus.Flags !== 4'b0100) $display("FAIL self_cond_flags: got %b want 0100", bus.Flags); else passed++;
    checks++; if (bus.SquashCnt !== m_cnt) $display("FAIL self_cond_cnt: got %0d want %0d", bus.SquashCnt, m_cnt); else passed++;
    $display("cmp_branch: flags %b count %0d", bus.Flags, bus.SquashCnt);
  endtask

  task automatic test_partial_flags();
    issue(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    issue(1, 4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    checks++; if (bus.Flags !== 4'b0011) $display("FAIL partial_nz: got %b want 0011", bus.Flags); else passed++;
    issue(1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    checks++; if (bus.Flags !== 4'b0000) $display("FAIL partial_cv: got %b want 0000", bus.Flags); else passed++;
    $display("partial_flags: flags %b", bus.Flags);
  endtask

  task automatic test_signed();
    logic [3:0] conds [4] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
    logic       want  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    issue(1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    for (int i = 0; i < 4; i++) begin
      issue(1, conds[i], 4'b0000, 2'b00, 1, 0, 0, 0, 0); e = sb.pop_front();
      checks++; if (bus.CondExE !== want[i]) $display("FAIL signed_nv10_c%b: got %b want %b", conds[i], bus.CondExE, want[i]); else passed++;
      tick();
    end
    issue(1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
    issue(1, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0); e = sb.pop_front();
    checks++; if (bus.CondExE !== 1'b1) $display("FAIL signed_gt_nv11: got %b want 1", bus.CondExE); else passed++;
    tick();
    issue(1, 4'b1111, 4'b0000, 2'b00, 1, 1, 1, 0, 0); e = sb.pop_front();
    checks++; if (bus.CondExE !== 1'b0) $display("FAIL nv_never: got %b want 0", bus.CondExE); else passed++;
    tick();
    $display("signed: count %0d", bus.SquashCnt);
  endtask

  task automatic test_all_conds();
    logic [3:0] fvals [4] = '{4'b0110, 4'b1011, 4'b0010, 4'b1101};
    for (int k = 0; k < 4; k++) begin
      issue(1, 4'b1110, fvals[k], 2'b11, 0, 0, 0, 0, 0); e = sb.pop_front(); tick();
      for (int c = 0; c < 16; c++) begin
        issue(1, 4'(c), 4'b0000, 2'b00, 1, 1, 1, 0, 0); e = sb.pop_front();
        checks++;
        if (bus.CondExE !== e.cx || bus.RegWriteGE !== e.rg || bus.MemWriteGE !== e.mg || bus.PCSrcGE !== e.pg)
          $display("FAIL cond_%b_flags_%b: got cx%b rg%b mg%b pg%b want cx%b rg%b mg%b pg%b", 4'(c), fvals[k],
                   bus.CondExE, bus.RegWriteGE, bus.MemWriteGE, bus.PCSrcGE, e.cx, e.rg, e.mg, e.pg);
        else passed++;
        tick();
      end
      checks++; if (bus.SquashCnt !== m_cnt) $display("FAIL all_conds_cnt: got %0d want %0d", bus.SquashCnt, m_cnt); else passed++;
      $display("all_conds: flags %b count %0d", fvals[k], bus.SquashCnt);
    end
  endtask

  task automatic test_stall_flush();
    logic [3:0] f0;
    logic [15:0] c0;
    f0 = bus.Flags; c0 = bus.SquashCnt;
    issue(1, 4'b1110, ~f0, 2'b11, 1, 0, 0, 1, 0); e = sb.pop_front();
    checks++; if (bus.RegWriteGE !== 1'b1) $display("FAIL stall_rg: got %b want 1", bus.RegWriteGE); else passed++;
    tick();
    checks++; if (bus.Flags !== f0) $display("FAIL stall_flags: got %b want %b", bus.Flags, f0); else passed++;
    issue(1, 4'b1111, 4'b0000, 2'b00, 1, 0, 0, 1, 0); e = sb.pop_front(); tick();
    checks++; if (bus.SquashCnt !== c0) $display("FAIL stall_cnt: got %0d want %0d", bus.SquashCnt, c0); else passed++;
    issue(1, 4'b1111, ~f0, 2'b11, 1, 1, 1, 0, 1); e = sb.pop_front();
    checks++; if ({bus.CondExE, bus.RegWriteGE, bus.MemWriteGE, bus.PCSrcGE} !== 4'b0000)
      $display("FAIL flush_outs: got %b want 0000", {bus.CondExE, bus.RegWriteGE, bus.MemWriteGE, bus.PCSrcGE}); else passed++;
    tick();
    checks++; if (bus.SquashCnt !== c0) $display("FAIL flush_cnt: got %0d want %0d", bus.SquashCnt, c0); else passed++;
    issue(1, 4'b1110, ~f0, 2'b11, 1, 1, 1, 0, 1); e = sb.pop_front(); tick();
    checks++; if (bus.Flags !== f0) $display("FAIL flush_flags: got %b want %b", bus.Flags, f0); else passed++;
    issue(1, 4'b1110, ~f0, 2'b11, 1, 1, 1, 1, 1); e = sb.pop_front();
    checks++; if ({bus.CondExE, bus.RegWriteGE, bus.MemWriteGE, bus.PCSrcGE} !== 4'b0000)
      $display("FAIL stall_flush_outs: got %b want 0000", {bus.CondExE, bus.RegWriteGE, bus.MemWriteGE, bus.PCSrcGE}); else passed++;
    tick();
    checks++; if (bus.Flags !== f0 || bus.SquashCnt !== c0)
      $display("FAIL stall_flush_state: got %b/%0d want %b/%0d", bus.Flags, bus.SquashCnt, f0, c0); else passed++;
    $display("stall_flush: flags %b count %0d", bus.Flags, bus.SquashCnt);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      e = sb.pop_front();
      checks++;
      if (bus.CondExE !== e.cx || bus.RegWriteGE !== e.rg || bus.MemWriteGE !== e.mg || bus.PCSrcGE !== e.pg ||
          bus.Flags !== e.fl || bus.SquashCnt !== e.cnt)
        $display("FAIL b2b_%0d: got cx%b rg%b mg%b pg%b fl%b cnt%0d want cx%b rg%b mg%b pg%b fl%b cnt%0d", i,
                 bus.CondExE, bus.RegWriteGE, bus.MemWriteGE, bus.PCSrcGE, bus.Flags, bus.SquashCnt,
                 e.cx, e.rg, e.mg, e.pg, e.fl, e.cnt);
      else passed++;
      tick();
    end
    checks++; if (bus.Flags !== m_flags || bus.SquashCnt !== m_cnt)
      $display("FAIL b2b_final: got %b/%0d want %b/%0d", bus.Flags, bus.SquashCnt, m_flags, m_cnt); else passed++;
    $display("back_to_back: flags %b count %0d", bus.Flags, bus.SquashCnt);
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    bus4.ValidE = 1; bus4.CondE = 4'b1111; bus4.RegWriteE = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      want = (i > 15) ? 4'd15 : 4'(i);
      checks++; if (bus4.SquashCnt !== want) $display("FAIL sat_%0d: got %0d want %0d", i, bus4.SquashCnt, want); else passed++;
    end
    bus4.ValidE = 0;
    $display("saturation: count %0d", bus4.SquashCnt);
  endtask

  initial begin
    test_reset();
    test_cmp_branch();
    test_partial_flags();
    test_signed();
    test_all_conds();
    test_stall_flush();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
